uart_rx_frame_check: RTL
========================

Name: uart_rx_frame_check

Overview:
- Parametrised successor to the UART RX start-bit checker: one block checks a whole received frame.
- Checks start bit, LSB-first data deserialisation, optional even/odd parity, and 1 or 2 stop bits.
- Sits between the RX oversampling/majority-vote sampler (supplies sampled_bit + sample_valid strobe) and the RX data sink / register file.
- Replaces separate start/parity/stop check blocks; emits per-frame error strobes and parallel data.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits checked per frame (1 or 2).
- CNT_WIDTH, 8, error counter width (used only with UART_RX_ERR_CNT_EN).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- chk_en  in  1  block enable; low aborts any frame.
- frame_start  in  1  one-cycle pulse from upstream falling-edge detector.
- par_en  in  1  parity bit present.
- par_typ  in  1  0 = even, 1 = odd.
- sampled_bit  in  1  voted bit value.
- sample_valid  in  1  one-cycle strobe qualifying sampled_bit.
- p_data  out  DATA_WIDTH  last good frame data.
- data_valid  out  1  pulse: frame complete, no errors.
- frame_done  out  1  pulse: frame ended (good or bad, incl. glitch).
- strt_glitch  out  1  pulse: start bit sampled 1.
- par_err  out  1  pulse: parity mismatch.
- stp_err  out  1  pulse: any stop bit sampled 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, p_data = 0, FSM = IDLE, counters/shift register cleared.
- All outputs registered; strobes are single-cycle, asserted the clock after the deciding sample_valid.
- FSM states:
  - IDLE: on chk_en & frame_start, latch par_en/par_typ, clear shift register and bit_cnt, go to START.
  - START: on sample_valid:
    - sampled_bit = 1: pulse strt_glitch + frame_done, go to IDLE.
    - sampled_bit = 0: go to DATA.
  - DATA: on sample_valid, shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]} (LSB first); bit_cnt++. After the DATA_WIDTH-th sample, go to PARITY if latched par_en, else STOP.
  - PARITY: on sample_valid, expected bit = ^shreg (even) or ~^shreg (odd); a mismatch sets internal par_fail. Go to STOP.
  - STOP: on each sample_valid, sampled_bit = 0 sets internal stp_fail; stop_cnt++.
    - After STOP_BITS samples, go to IDLE and pulse frame_done.
    - par_err pulses if par_fail; stp_err pulses if stp_fail.
    - If neither fail flag is set: p_data <= shreg and data_valid pulses.
    - If either fail flag is set: p_data holds its previous value.
- Boundary conditions:
  - Stop check: remaining stop samples are still consumed after a failing stop bit.
  - frame_start while busy: ignored.
  - frame_start and sample_valid in the same cycle while in IDLE: the sample is ignored.
  - sample_valid outside a frame (IDLE): ignored.
  - chk_en low in any state: FSM goes to IDLE next cycle, fail flags cleared, no strobes, p_data held.
  - par_en/par_typ changes mid-frame: no effect until the next frame_start.
  - bit_cnt/stop_cnt sized $clog2 of their limits and never wrap within a frame.
  - Back-to-back frames: frame_start is accepted on the cycle after the return to IDLE.
  - Reset mid-frame: immediate return to reset state; no strobes.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined: adds input cnt_clr plus outputs glitch_cnt, par_err_cnt, stp_err_cnt (CNT_WIDTH each).
  - Each counter increments on its error strobe and saturates at all-ones.
  - cnt_clr zeroes all three; cnt_clr has priority over a same-cycle increment.
  - All counters reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- DATA_WIDTH=8, par_en=1, par_typ=0. Send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 → p_data=0xA5, data_valid=1 and frame_done=1 for one cycle; par_err=stp_err=strt_glitch=0.
- Same frame with parity bit 1 → par_err=1, frame_done=1, data_valid=0, p_data unchanged at previous value.
- frame_start, then first sample_valid with sampled_bit=1 → strt_glitch=1 and frame_done=1 next cycle, busy=0; following samples ignored.
- STOP_BITS=2, par_en=0, data 0x3C, stop samples 1 then 0 → stp_err=1, data_valid=0, frame ends after the 2nd stop sample.
- chk_en dropped after 4 data samples → busy=0 next cycle, no strobes; next full 0x5A frame decodes correctly.
- With UART_RX_ERR_CNT_EN, CNT_WIDTH=2: five parity-error frames → par_err_cnt=3 (saturated); cnt_clr pulse → 0.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART RX whole-frame checker (start, data, parity, stop)
//
// Purpose: deserialises one UART frame from the upstream sampler's voted bits and
//   flags start-glitch, parity and stop errors with single-cycle registered strobes.
// Optional feature macro: UART_RX_ERR_CNT_EN adds saturating per-error counters.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   chk_en                    block enable; low aborts any frame in flight
//   frame_start               pulse from falling-edge detector, starts a frame in IDLE
//   par_en, par_typ           parity present / 0 even 1 odd (latched at frame_start)
//   sampled_bit, sample_valid voted bit and its qualifying strobe
//   p_data                    data of the last error-free frame
//   data_valid, frame_done    good-frame pulse / any-frame-end pulse
//   strt_glitch, par_err, stp_err  error pulses
//   busy                      FSM outside IDLE
//   cnt_clr, glitch_cnt, par_err_cnt, stp_err_cnt  (UART_RX_ERR_CNT_EN only)
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chk_en,
  input  logic                  frame_start,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  input  logic                  sample_valid,
`ifdef UART_RX_ERR_CNT_EN
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
`endif
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SCW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [BCW-1:0] BitLast  = BCW'(DATA_WIDTH - 1);
  localparam logic [SCW-1:0] StopLast = SCW'(STOP_BITS - 1);

  // CNT_WIDTH only sizes the optional error counters.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]        stop_cnt_q, stop_cnt_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d, stp_fail_q, stp_fail_d;
  logic                  data_valid_q, data_valid_d, frame_done_q, frame_done_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic                  stp_fail_now;

  // Fail flag including the stop sample currently being presented.
  assign stp_fail_now = stp_fail_q | ~sampled_bit;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    p_data_d      = p_data_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_fail_d    = par_fail_q;
    stp_fail_d    = stp_fail_q;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    if (!chk_en) begin
      state_d    = S_IDLE;
      par_fail_d = 1'b0;
      stp_fail_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
            par_fail_d = 1'b0;
            stp_fail_d = 1'b0;
            state_d    = S_START;
          end
        end
        S_START: begin
          if (sample_valid) begin
            if (sampled_bit) begin
              strt_glitch_d = 1'b1;
              frame_done_d  = 1'b1;
              state_d       = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sample_valid) begin
            shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
            if (bit_cnt_q == BitLast) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (sample_valid) begin
            par_fail_d = sampled_bit != (par_typ_q ? ~^shreg_q : ^shreg_q);
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          if (sample_valid) begin
            stp_fail_d = stp_fail_now;
            if (stop_cnt_q == StopLast) begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
              par_err_d    = par_fail_q;
              stp_err_d    = stp_fail_now;
              if (!par_fail_q && !stp_fail_now) begin
                p_data_d     = shreg_q;
                data_valid_d = 1'b1;
              end
            end else begin
              stop_cnt_d = stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      p_data_q      <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_fail_q    <= 1'b0;
      stp_fail_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      p_data_q      <= p_data_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_fail_q    <= par_fail_d;
      stp_fail_q    <= stp_fail_d;
      data_valid_q  <= data_valid_d;
      frame_done_q  <= frame_done_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  assign p_data      = p_data_q;
  assign data_valid  = data_valid_q;
  assign frame_done  = frame_done_q;
  assign strt_glitch = strt_glitch_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign busy        = (state_q != S_IDLE);

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] glitch_cnt_q, par_err_cnt_q, stp_err_cnt_q;

  // Counters follow the registered strobes, so they move one cycle after the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt_q  <= '0;
      par_err_cnt_q <= '0;
      stp_err_cnt_q <= '0;
    end else if (cnt_clr) begin
      glitch_cnt_q  <= '0;
      par_err_cnt_q <= '0;
      stp_err_cnt_q <= '0;
    end else begin
      if (strt_glitch_q && (glitch_cnt_q != '1))  glitch_cnt_q  <= glitch_cnt_q + 1'b1;
      if (par_err_q && (par_err_cnt_q != '1))     par_err_cnt_q <= par_err_cnt_q + 1'b1;
      if (stp_err_q && (stp_err_cnt_q != '1))     stp_err_cnt_q <= stp_err_cnt_q + 1'b1;
    end
  end

  assign glitch_cnt  = glitch_cnt_q;
  assign par_err_cnt = par_err_cnt_q;
  assign stp_err_cnt = stp_err_cnt_q;
`endif

endmodule
